project_select_ctrl: RTL and testbench

Parametrised successor to the shared-bus project wrapper. It multiplexes Wishbone slave traffic, IRQs and IO ownership among `NUM_PROJECTS` wrapped designs from a firmware-programmed select register. Project changes run through a drain/guard sequence, so there is never a cycle with two `active` lines high and no tristate fight on the IO bus. It sits in `user_project_wrapper` between the Caravel Wishbone/IRQ pins and the wrapped projects.

---
 rtl/project_select_pkg.sv | 21 ++
 rtl/project_resp_mux.sv | 26 ++
 rtl/project_select_ctrl.sv | 175 +++++++++++++++++
 tb/tb_project_select_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/project_select_pkg.sv
// Shared definitions for the project select controller: register offsets,
// STATUS bit positions and the switch sequencer state encoding.
package project_select_pkg;

  localparam logic [3:0] SEL_OFS  = 4'h0;
  localparam logic [3:0] STAT_OFS = 4'h4;

  localparam int SEL_EN_BIT     = 31;
  localparam int ST_BUSY_BIT    = 0;
  localparam int ST_DROP_BIT    = 1;
  localparam int ST_RERR_BIT    = 2;
  localparam int ST_EVT_BIT     = 3;
  localparam int ST_IDX_LSB     = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GUARD = 2'd2
  } sel_state_t;

endpackage

// File: rtl/project_resp_mux.sv
// One-hot (or all-zero) select of per-project ack, read data and IRQs.
// A zero select yields all-zero outputs.
module project_resp_mux #(
  parameter int NUM_PROJECTS = 8
) (
  input  logic [NUM_PROJECTS-1:0]    sel,
  input  logic [NUM_PROJECTS-1:0]    ack_in,
  input  logic [32*NUM_PROJECTS-1:0] dat_in,
  input  logic [3*NUM_PROJECTS-1:0]  irq_in,
  output logic                       ack,
  output logic [31:0]                dat,
  output logic [2:0]                 irq
);

  always_comb begin
    ack = 1'b0;
    dat = '0;
    irq = '0;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      ack = ack | (sel[k] & ack_in[k]);
      dat = dat | ({32{sel[k]}} & dat_in[32*k +: 32]);
      irq = irq | ({3{sel[k]}} & irq_in[3*k +: 3]);
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// Firmware-driven project selector: Wishbone/IRQ mux with a drain/guard switch sequence.
// Optional macro PROJ_SEL_IRQ_EN adds a switch-done event on user_irq[2] / STATUS bit3.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int          NUM_PROJECTS = 8,
  parameter int          GUARD_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_n,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  input  logic [NUM_PROJECTS-1:0]    proj_ack_i,
  input  logic [32*NUM_PROJECTS-1:0] proj_dat_i,
  input  logic [3*NUM_PROJECTS-1:0]  proj_irq_i,
  output logic [2:0]                 user_irq,
  output logic [NUM_PROJECTS-1:0]    active
);

  localparam int                    CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [4:0]            NP    = 5'(NUM_PROJECTS);
  localparam logic [NUM_PROJECTS-1:0] ONE = NUM_PROJECTS'(1);

  sel_state_t       state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             pend_en;
  logic [3:0]       pend_idx;
  logic [3:0]       cur_idx;
  logic             drop, range_err, done_evt;
  logic             ctrl_ack, idle_ack;

  logic             hit, req, fwd, wr, sel_wr, stat_wr, range_bad, busy;
  logic             accept, drain_done, guard_done;
  logic             mux_ack;
  logic [31:0]      mux_dat, ctrl_rdata;
  logic [2:0]       mux_irq;
  logic [3:0]       ofs;
  logic             unused_bits;

  assign unused_bits = &{1'b0, wbs_sel_i, wbs_dat_i[30:4]};

  assign ofs       = wbs_adr_i[3:0];
  assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req       = wbs_stb_i & wbs_cyc_i;
  assign fwd       = req & ~hit & (|active);
  // Register writes commit in the ack cycle while the master still holds the request.
  assign wr        = ctrl_ack & req & hit & wbs_we_i;
  assign sel_wr    = wr & (ofs == SEL_OFS);
  assign stat_wr   = wr & (ofs == STAT_OFS);
  assign range_bad = ({1'b0, wbs_dat_i[3:0]} >= NP);
  assign busy      = (state != ST_IDLE);

  project_resp_mux #(.NUM_PROJECTS(NUM_PROJECTS)) u_mux (
    .sel    (active),
    .ack_in (proj_ack_i),
    .dat_in (proj_dat_i),
    .irq_in (proj_irq_i),
    .ack    (mux_ack),
    .dat    (mux_dat),
    .irq    (mux_irq)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= ST_IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    drain_done = 1'b0;
    guard_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_wr && !range_bad) begin
          accept     = 1'b1;
          next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!wbs_cyc_i) begin
          drain_done = 1'b1;
          next_state = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt == '0) begin
          guard_done = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt       <= '0;
      pend_en   <= 1'b0;
      pend_idx  <= '0;
      cur_idx   <= '0;
      active    <= '0;
      drop      <= 1'b0;
      range_err <= 1'b0;
      ctrl_ack  <= 1'b0;
      idle_ack  <= 1'b0;
    end else begin
      ctrl_ack <= req & hit & ~ctrl_ack;
      idle_ack <= req & ~hit & ~(|active) & ~idle_ack;
      if (accept) begin
        pend_en  <= wbs_dat_i[SEL_EN_BIT];
        pend_idx <= wbs_dat_i[3:0];
      end
      if (drain_done) begin
        active <= '0;
        cnt    <= CNT_W'(GUARD_CYCLES - 1);
      end else if (state == ST_GUARD && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (guard_done) begin
        active  <= pend_en ? (ONE << pend_idx) : '0;
        cur_idx <= pend_idx;
      end
      if (stat_wr) begin
        drop      <= 1'b0;
        range_err <= 1'b0;
      end else begin
        if (sel_wr && range_bad)          range_err <= 1'b1;
        if (sel_wr && !range_bad && busy) drop      <= 1'b1;
      end
    end
  end

`ifdef PROJ_SEL_IRQ_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)       done_evt <= 1'b0;
    else if (stat_wr)    done_evt <= 1'b0;
    else if (guard_done) done_evt <= 1'b1;
  end
  assign user_irq = mux_irq | {done_evt, 2'b00};
`else
  assign done_evt = 1'b0;
  assign user_irq = mux_irq;
`endif

  always_comb begin
    ctrl_rdata = '0;
    case (ofs)
      SEL_OFS: begin
        ctrl_rdata[SEL_EN_BIT] = pend_en;
        ctrl_rdata[3:0]        = pend_idx;
      end
      STAT_OFS: begin
        ctrl_rdata[ST_BUSY_BIT]                  = busy;
        ctrl_rdata[ST_DROP_BIT]                  = drop;
        ctrl_rdata[ST_RERR_BIT]                  = range_err;
        ctrl_rdata[ST_EVT_BIT]                   = done_evt;
        ctrl_rdata[ST_IDX_LSB+3:ST_IDX_LSB]      = cur_idx;
      end
      default: ctrl_rdata = '0;
    endcase
  end

  // Idle-ack path returns zero data; project path is forwarded combinationally.
  assign wbs_ack_o = ctrl_ack | idle_ack | (fwd & mux_ack);
  assign wbs_dat_o = ctrl_ack ? ctrl_rdata : (fwd ? mux_dat : 32'h0);

endmodule

// File: tb/tb_project_select_ctrl.sv
// Directed self-checking bench for project_select_ctrl (NUM_PROJECTS=8, GUARD_CYCLES=4).
`timescale 1ns/1ps
module tb_project_select_ctrl;

  localparam int          NP   = 8;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] SEL  = BASE + 32'h0;
  localparam logic [31:0] STAT = BASE + 32'h4;
`ifdef PROJ_SEL_IRQ_EN
  localparam logic [31:0] EVT  = 32'h0000_0008;
  localparam logic [2:0]  IEVT = 3'b100;
`else
  localparam logic [31:0] EVT  = 32'h0;
  localparam logic [2:0]  IEVT = 3'b000;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]      sel = 4'hF;
  logic [31:0]     adr = '0, wdat = '0;
  logic            ack;
  logic [31:0]     rdat;
  logic [NP-1:0]   proj_ack = '0;
  logic [32*NP-1:0] proj_dat = '0;
  logic [3*NP-1:0] proj_irq = '0;
  logic [2:0]      user_irq;
  logic [NP-1:0]   active;

  int checks = 0;
  int passes = 0;
  int lat;
  logic [31:0] got;

  project_select_ctrl #(.NUM_PROJECTS(NP), .GUARD_CYCLES(4), .BASE_ADDR(BASE)) dut (
    .wb_clk_i  (clk),
    .wb_rst_n  (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .proj_ack_i(proj_ack),
    .proj_dat_i(proj_dat),
    .proj_irq_i(proj_irq),
    .user_irq  (user_irq),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_start(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge clk); #1;
    adr = a; we = w; wdat = d; stb = 1'b1; cyc = 1'b1;
  endtask

  // Returns number of falling edges until ack (1 = same cycle, 2 = next cycle).
  task automatic bus_wait(output int l, output logic [31:0] d);
    l = 99;
    d = 32'hDEAD_BEEF;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ack) begin
        l = i;
        d = rdat;
        break;
      end
    end
  endtask

  task automatic bus_end();
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [31:0] a, input logic [31:0] d);
    bus_start(a, 1'b1, d);
    bus_wait(lat, got);
    check({tag, "_lat"}, lat, 2);
    bus_end();
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus_start(a, 1'b0, 32'h0);
    bus_wait(lat, got);
    check({tag, "_lat"}, lat, 2);
    check(tag, got, exp);
    bus_end();
  endtask

  initial begin
    for (int k = 0; k < NP; k++) proj_dat[32*k +: 32] = 32'hA5A5_0000 | k;
    proj_dat[32*2 +: 32] = 32'h1234_5678;
    proj_irq = '1;

    // Reset state
    #12;
    check("rst_active", active, 0);
    check("rst_ack", ack, 0);
    check("rst_dat", rdat, 0);
    check("rst_irq", user_irq, 0);
    @(negedge clk); rst_n = 1'b1;
    proj_irq = '0;

    // Non-control access with no project: fallback ack, zero data
    bus_start(32'h0000_1000, 1'b0, 32'h0);
    bus_wait(lat, got);
    check("idle_lat", lat, 2);
    check("idle_dat", got, 0);
    bus_end();
    rd_reg("rst_status", STAT, 32'h0);

    // Switch to project 2
    wr_reg("sel2", SEL, 32'h8000_0002);
    @(negedge clk); check("sw_a1", active, 0);
    bus_start(STAT, 1'b0, 32'h0);
    bus_wait(lat, got);
    check("sw_busy", got, 32'h0000_0001);
    check("sw_a3", active, 0);
    bus_end();
    @(negedge clk); check("sw_a4", active, 0);
    @(negedge clk); check("sw_a5", active, 0);
    @(negedge clk); check("sw_a6", active, 8'b0000_0100);
    check("sw_irq", user_irq, IEVT);
    rd_reg("sw_status", STAT, 32'h0000_0200 | EVT);
    rd_reg("sw_select", SEL, 32'h8000_0002);

    // Forwarding from project 2 with every project acking
    proj_ack = '1;
    proj_irq = {NP{3'b010}};
    proj_irq[3*2 +: 3] = 3'b101;
    bus_start(32'h0000_2000, 1'b0, 32'h0);
    bus_wait(lat, got);
    check("fwd_lat", lat, 1);
    check("fwd_dat", got, 32'h1234_5678);
    check("fwd_irq", user_irq, 3'b101);
    bus_end();
    @(negedge clk); check("fwd_ack_off", ack, 0);
    proj_ack = '0;
    proj_irq = '0;

    // Out-of-range index
    wr_reg("sel9", SEL, 32'h8000_0009);
    repeat (6) @(negedge clk);
    check("rng_active", active, 8'b0000_0100);
    rd_reg("rng_status", STAT, 32'h0000_0204 | EVT);
    rd_reg("rng_select", SEL, 32'h8000_0002);
    wr_reg("stat_clr1", STAT, 32'h0);
    rd_reg("rng_cleared", STAT, 32'h0000_0200);
    check("clr_irq", user_irq, 0);

    // Write during a switch is dropped, first target completes
    wr_reg("sel5", SEL, 32'h8000_0005);
    @(negedge clk); check("drop_a1", active, 8'b0000_0100);
    bus_start(SEL, 1'b1, 32'h8000_0001);
    @(negedge clk); check("drop_a2", active, 0);
    bus_wait(lat, got);
    check("drop_lat", lat, 1);
    bus_end();
    @(negedge clk); check("drop_a4", active, 0);
    @(negedge clk); check("drop_a5", active, 0);
    @(negedge clk); check("drop_a6", active, 8'b0010_0000);
    rd_reg("drop_status", STAT, 32'h0000_0502 | EVT);
    wr_reg("stat_clr2", STAT, 32'h0);
    rd_reg("drop_cleared", STAT, 32'h0000_0500);

    // Reselecting the current project still blanks active
    wr_reg("resel5", SEL, 32'h8000_0005);
    @(negedge clk); check("resel_a1", active, 8'b0010_0000);
    @(negedge clk); check("resel_a2", active, 0);
    repeat (4) @(negedge clk);
    check("resel_done", active, 8'b0010_0000);

    // Reset mid-switch while active is still the old project
    wr_reg("sel3", SEL, 32'h8000_0003);
    @(negedge clk); check("rstmid_a1", active, 8'b0010_0000);
    proj_irq = '1;
    rst_n = 1'b0;
    #1;
    check("rstmid_active", active, 0);
    check("rstmid_irq", user_irq, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    proj_irq = '0;
    repeat (8) @(negedge clk);
    check("rstpost_active", active, 0);
    rd_reg("rstpost_status", STAT, 32'h0);
    rd_reg("rstpost_select", SEL, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
